// File: rtl/time_set_ctrl.sv
// time_set_ctrl: front-panel time-setting controller.
// Takes three raw push buttons (select, increment, decrement). Each one goes
// through a 2-flop synchronizer and a counter debouncer. A mode FSM steps
// RUN -> SET_HR -> SET_MIN -> RUN on each select press. In the set modes,
// inc/dec press events and auto-repeat intervals become single-cycle enable
// pulses to the selected hour/minute counter.
//
// Output pulse contract: hr_en / min_en act as one-cycle valid strobes with
// no back-pressure. updown qualifies the strobe and is meaningful whenever
// either enable is high. Between strobes it holds the last direction. At most
// one enable is high in any cycle.
module time_set_ctrl #(
  parameter int DB_CYCLES    = 16,
  parameter int REPEAT_DELAY = 64,
  parameter int REPEAT_RATE  = 16,
  parameter int CNT_W        = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic       hr_en,
  output logic       min_en,
  output logic       updown,
  output logic [1:0] sel_field,
  output logic       set_active
);

  // Mode encoding matches sel_field directly, so sel_field is the FSM state.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  localparam int B_SEL = 0;
  localparam int B_INC = 1;
  localparam int B_DEC = 2;

  localparam logic [CNT_W-1:0] DB_LIM    = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_LIM = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Button vectors are indexed {dec, inc, sel}.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       db_q;
  logic [CNT_W-1:0] db_cnt [3];

  logic sel_pe;
  logic inc_pe;
  logic dec_pe;
  logic inc_db;
  logic dec_db;

  mode_t state;
  mode_t state_nxt;

  logic             rpt_active;
  logic             rpt_dir;
  logic             rpt_first;
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_lim;
  logic             rpt_held;

  logic adjust;
  logic conflict;
  logic fire_new;
  logic fire_rpt;
  logic fire;
  logic fire_dir;

  assign raw = {btn_dec, btn_inc, btn_sel};

  // Two-flop synchronizer per button; sync2 follows the raw pin 2 cycles later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive cycles of disagreement, toggle the level once
  // the count hits DB_CYCLES, clear the count on any agreeing cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      db_q <= db;
      for (int i = 0; i < 3; i++) begin
        if (db_cnt[i] == DB_LIM) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else if (sync2[i] != db[i]) begin
          db_cnt[i] <= db_cnt[i] + CNT_ONE;
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press event is the single cycle where the debounced level has just risen.
  assign sel_pe = db[B_SEL] & ~db_q[B_SEL];
  assign inc_pe = db[B_INC] & ~db_q[B_INC];
  assign dec_pe = db[B_DEC] & ~db_q[B_DEC];
  assign inc_db = db[B_INC];
  assign dec_db = db[B_DEC];

  // Mode FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Mode FSM next state: each select press advances the mode.
  always_comb begin
    state_nxt = state;
    if (sel_pe) begin
      case (state)
        RUN:     state_nxt = SET_HR;
        SET_HR:  state_nxt = SET_MIN;
        SET_MIN: state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // Mode FSM outputs, decoded from the registered state.
  always_comb begin
    sel_field  = state;
    set_active = (state != RUN);
  end

  // Pulse decision. A press of one adjust button while the other is held is a
  // conflict: nothing fires and any repeat is dropped. Both pressing in the
  // same cycle is covered too, since each sees the other already high. A
  // select press in the same cycle wins over inc/dec.
  always_comb begin
    adjust   = (state != RUN);
    conflict = (inc_pe & dec_db) | (dec_pe & inc_db);
    rpt_held = rpt_dir ? inc_db : dec_db;
    rpt_lim  = rpt_first ? DELAY_LIM : RATE_LIM;
    fire_new = adjust & ~sel_pe & ~conflict & (inc_pe | dec_pe);
    fire_rpt = adjust & ~sel_pe & ~conflict & rpt_active & rpt_held &
               (rpt_cnt == rpt_lim);
    fire     = fire_new | fire_rpt;
    fire_dir = fire_new ? inc_pe : rpt_dir;
  end

  // Auto-repeat tracker. rpt_cnt is 1 in the cycle after a pulse, so it equals
  // the limit one cycle before the next registered pulse is due.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_active <= 1'b0;
      rpt_dir    <= 1'b1;
      rpt_first  <= 1'b1;
      rpt_cnt    <= '0;
    end else if (!adjust || sel_pe || conflict) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b1;
      rpt_cnt    <= '0;
    end else if (fire_new) begin
      rpt_active <= 1'b1;
      rpt_dir    <= inc_pe;
      rpt_first  <= 1'b1;
      rpt_cnt    <= CNT_ONE;
    end else if (rpt_active && !rpt_held) begin
      rpt_active <= 1'b0;
      rpt_first  <= 1'b1;
      rpt_cnt    <= '0;
    end else if (fire_rpt) begin
      rpt_first  <= 1'b0;
      rpt_cnt    <= CNT_ONE;
    end else if (rpt_active) begin
      rpt_cnt    <= rpt_cnt + CNT_ONE;
    end
  end

  // Registered enable pulses, steered by the current mode; updown holds.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hr_en  <= 1'b0;
      min_en <= 1'b0;
      updown <= 1'b1;
    end else begin
      hr_en  <= fire & (state == SET_HR);
      min_en <= fire & (state == SET_MIN);
      if (fire) begin
        updown <= fire_dir;
      end
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
// Stimulus is scheduled on absolute clock edges. An edge index c means the
// input is first sampled at edge c. Each expected output event is stamped with
// the edge after which it must be visible and is pushed into exp_q. The
// monitor pops an entry whenever the DUT shows a pulse or a mode change.
module tb_time_set_ctrl;

  localparam int W = 22;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       hr_en;
  logic       min_en;
  logic       updown;
  logic [1:0] sel_field;
  logic       set_active;

  int         cyc       = 0;
  int         n_chk     = 0;
  int         n_fail    = 0;
  int         pulse_cnt = 0;
  bit         mon_on    = 1'b0;
  logic [1:0] last_sel  = 2'b00;
  logic [1:0] m_sel     = 2'b00;
  logic       m_ud      = 1'b1;
  logic [W-1:0] exp_q[$];

  time_set_ctrl #(
    .DB_CYCLES(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_sel(btn_sel),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .hr_en(hr_en),
    .min_en(min_en),
    .updown(updown),
    .sel_field(sel_field),
    .set_active(set_active)
  );

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event word: {edge[15:0], hr_en, min_en, updown, sel_field, set_active}.
  function automatic logic [W-1:0] pack_ev(input int c, input logic hr, input logic mn,
                                           input logic ud, input logic [1:0] s);
    logic [15:0] cc;
    cc = 16'(c);
    return {cc, hr, mn, ud, s, (s != 2'b00)};
  endfunction

  function void exp_sel(input int c, input logic [1:0] s);
    m_sel = s;
    exp_q.push_back(pack_ev(c, 1'b0, 1'b0, m_ud, s));
  endfunction

  function void exp_pulse(input int c, input logic hr, input logic ud);
    m_ud = ud;
    exp_q.push_back(pack_ev(c, hr, ~hr, ud, m_sel));
  endfunction

  function void exp_reset(input int c);
    m_ud = 1'b1;
    exp_sel(c, 2'b00);
  endfunction

  // Advance so that inputs written next are first sampled at edge c.
  task automatic at(input int c);
    while (cyc < c - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_sel = v;
      1: btn_inc = v;
      default: btn_dec = v;
    endcase
  endtask

  task automatic press(input int which, input int t, input int hold);
    at(t);
    set_btn(which, 1'b1);
    at(t + hold);
    set_btn(which, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hr_en"}, 32'(hr_en), 32'd0);
    check({tag, "_min_en"}, 32'(min_en), 32'd0);
    check({tag, "_updown"}, 32'(updown), 32'd1);
    check({tag, "_sel_field"}, 32'(sel_field), 32'd0);
    check({tag, "_set_active"}, 32'(set_active), 32'd0);
  endtask

  // Scoreboard monitor: any pulse or mode change is one observed event.
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (mon_on && (hr_en || min_en || sel_field != last_sel)) begin
      act = pack_ev(cyc, hr_en, min_en, updown, sel_field);
      if (hr_en || min_en) pulse_cnt++;
      n_chk++;
      if (hr_en && min_en) begin
        n_fail++;
        $display("FAIL en_exclusive: both enables high at edge %0d", cyc);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h, nothing expected", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL event: got %h expected %h", act, e);
        end
      end
      last_sel = sel_field;
    end
  end

  initial begin
    // Reset held for edges 1..3, buttons low.
    at(3);
    @(negedge clk);
    check_reset_outputs("reset");
    at(4);
    reset  = 1'b1;
    mon_on = 1'b1;

    // Idle window: no pulses at all.
    at(104);
    check("idle_no_pulse", 32'(pulse_cnt), 32'd0);

    // Select cycles the mode; each change lands 7 edges after the raw press.
    exp_sel(117, 2'b01);
    exp_sel(137, 2'b10);
    exp_sel(157, 2'b00);
    press(0, 110, 10);
    press(0, 130, 10);
    press(0, 150, 10);

    // In RUN an increment press does nothing.
    press(1, 170, 8);

    // SET_HR: one increment press gives exactly one hr_en, direction up.
    exp_sel(197, 2'b01);
    press(0, 190, 10);
    exp_pulse(217, 1'b1, 1'b1);
    press(1, 210, 8);

    // Glitches of 1, 2, 3 cycles are filtered. A following real press still
    // lands exactly on +7.
    press(1, 240, 1);
    press(1, 250, 2);
    press(1, 260, 3);
    exp_pulse(282, 1'b1, 1'b1);
    press(1, 275, 8);

    // SET_MIN with dec held: pulses at +7, +27, +32, +37, all down. The
    // debounced release lands 6 edges after the raw release. Releasing at +35
    // drops the level at +41, so the +42 repeat must not appear.
    exp_sel(307, 2'b10);
    press(0, 300, 10);
    exp_pulse(327, 1'b0, 1'b0);
    exp_pulse(347, 1'b0, 1'b0);
    exp_pulse(352, 1'b0, 1'b0);
    exp_pulse(357, 1'b0, 1'b0);
    press(2, 320, 35);

    // Back to SET_HR; inc held, then dec pressed mid-repeat cancels it.
    exp_sel(387, 2'b00);
    exp_sel(407, 2'b01);
    press(0, 380, 10);
    press(0, 400, 10);
    exp_pulse(427, 1'b1, 1'b1);
    at(420);
    btn_inc = 1'b1;
    at(435);
    btn_dec = 1'b1;
    at(470);
    btn_inc = 1'b0;
    btn_dec = 1'b0;

    // inc and dec pressed together: no pulse.
    at(490);
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    at(500);
    btn_inc = 1'b0;
    btn_dec = 1'b0;

    // Pulsing resumes on a fresh press after both are released.
    exp_pulse(527, 1'b1, 1'b1);
    press(1, 520, 8);

    // Select while inc held: mode moves to SET_MIN, no min_en until re-press.
    exp_pulse(547, 1'b1, 1'b1);
    exp_sel(557, 2'b10);
    at(540);
    btn_inc = 1'b1;
    press(0, 550, 10);
    at(600);
    btn_inc = 1'b0;
    exp_pulse(627, 1'b0, 1'b1);
    press(1, 620, 8);

    // Select and inc press events in the same cycle from SET_HR: the mode
    // change wins, and the held inc must not start a repeat in SET_MIN.
    exp_sel(657, 2'b00);
    exp_sel(677, 2'b01);
    press(0, 650, 10);
    press(0, 670, 10);
    exp_sel(707, 2'b10);
    at(700);
    btn_sel = 1'b1;
    btn_inc = 1'b1;
    at(710);
    btn_sel = 1'b0;
    at(740);
    btn_inc = 1'b0;

    // Reset mid-repeat on the edge a repeat pulse is due. sel and inc stay
    // held through reset, so both produce press events after release. The
    // select moves RUN -> SET_HR, and the inc event falls in RUN and is
    // ignored.
    exp_pulse(767, 1'b0, 1'b1);
    exp_pulse(787, 1'b0, 1'b1);
    exp_reset(792);
    exp_sel(801, 2'b01);
    at(760);
    btn_inc = 1'b1;
    at(791);
    btn_sel = 1'b1;
    at(792);
    reset = 1'b0;
    at(793);
    @(negedge clk);
    check_reset_outputs("midrepeat_reset");
    at(794);
    reset = 1'b1;
    at(810);
    btn_sel = 1'b0;
    at(860);
    btn_inc = 1'b0;

    // A normal press after all that still works in SET_HR.
    exp_pulse(887, 1'b1, 1'b1);
    press(1, 880, 8);

    at(930);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
